// File: rtl/led_scan_scheduler.sv
// led_scan_scheduler
//   Drives a 74HC595-style shift chain plus a one-hot row select for an 8x8
//   RGB LED matrix. Each row is shown in two colour phases (green, then
//   red+blue). Frames arrive through a single-entry shadow buffer and are
//   only promoted to the active buffer at a frame boundary (or on leaving
//   IDLE), so a frame is never displayed half-old / half-new.
//
// Ports
//   clk, reset_n      : clock, asynchronous active-low reset
//   en                : scan enable (sampled on tick cycles)
//   frame_in[191:0]   : row r = [24r+23:24r] = {R, G, B}
//   frame_valid/ready : shadow-buffer handshake (ready = shadow empty)
//   rowsOut[7:0]      : one-hot row select
//   shcp, stcp, mr,   : shift clock, latch clock, clear (low),
//   oe, ds            : output enable (low), serial data
//   frame_start       : one-cycle pulse when the active frame is swapped
module led_scan_scheduler #(
    parameter int DIV         = 128,
    parameter int ON_TICKS    = 380,
    parameter int CLR_TICKS   = 2,
    parameter int BLANK_TICKS = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [191:0] frame_in,
    input  logic         frame_valid,
    output logic         frame_ready,
    output logic [7:0]   rowsOut,
    output logic         shcp,
    output logic         stcp,
    output logic         mr,
    output logic         oe,
    output logic         ds,
    output logic         frame_start
);

    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MAX_A   = (ON_TICKS > 48) ? ON_TICKS : 48;
    localparam int MAX_B   = (CLR_TICKS > BLANK_TICKS) ? CLR_TICKS : BLANK_TICKS;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CLR_LAST   = CNT_W'(CLR_TICKS - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_TICKS - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(47);

    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   tcnt_q, tcnt_d;
    logic [2:0]         row_q, row_d;
    logic               phase_q, phase_d;
    logic [191:0]       active_q, active_d;
    logic [191:0]       shadow_q, shadow_d;
    logic               full_q, full_d;
    logic               shcp_q, shcp_d;
    logic               stcp_q, stcp_d;
    logic               mr_q, mr_d;
    logic               oe_q, oe_d;
    logic               ds_q, ds_d;
    logic               frame_start_q, frame_start_d;

    logic               tick;
    logic               swap;
    logic [CNT_W-1:0]   tnext;
    logic [23:0]        row_word;
    logic [23:0]        word;

    assign tick  = (div_q == DIV_LAST);
    assign tnext = tcnt_q + CNT_W'(1);

    // Masking the packed {R,G,B} row gives both phase words directly:
    // phase 0 keeps only G, phase 1 keeps R and B.
    assign row_word = active_q[24*row_q +: 24];
    assign word     = row_word & (phase_q ? 24'hFF00FF : 24'h00FF00);

    always_comb begin
        div_d         = tick ? '0 : div_q + DIV_W'(1);
        state_d       = state_q;
        tcnt_d        = tcnt_q;
        row_d         = row_q;
        phase_d       = phase_q;
        active_d      = active_q;
        shadow_d      = shadow_q;
        full_d        = full_q;
        shcp_d        = shcp_q;
        stcp_d        = stcp_q;
        mr_d          = mr_q;
        oe_d          = oe_q;
        ds_d          = ds_q;
        frame_start_d = 1'b0;
        swap          = 1'b0;

        // Output registers hold the values for the tick period that starts
        // at this edge, so each branch sets up the *next* tick's outputs.
        if (tick) begin
            case (state_q)
                S_IDLE: begin
                    if (en) begin
                        swap    = full_q;
                        row_d   = 3'd0;
                        phase_d = 1'b0;
                        tcnt_d  = '0;
                        mr_d    = 1'b0;
                        oe_d    = 1'b1;
                        state_d = S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    if (tcnt_q == CLR_LAST) begin
                        tcnt_d  = '0;
                        mr_d    = 1'b1;
                        shcp_d  = 1'b0;
                        ds_d    = word[0];
                        state_d = S_SHIFT;
                    end else begin
                        tcnt_d = tnext;
                    end
                end
                S_SHIFT: begin
                    if (tcnt_q == SHIFT_LAST) begin
                        tcnt_d  = '0;
                        shcp_d  = 1'b0;
                        stcp_d  = 1'b1;
                        state_d = S_LATCH;
                    end else begin
                        tcnt_d = tnext;
                        // Odd ticks raise shcp; even ticks present the next bit.
                        if (tnext[0]) begin
                            shcp_d = 1'b1;
                        end else begin
                            shcp_d = 1'b0;
                            ds_d   = word[tnext[5:1]];
                        end
                    end
                end
                S_LATCH: begin
                    if (tcnt_q == '0) begin
                        tcnt_d = CNT_W'(1);
                        stcp_d = 1'b0;
                        ds_d   = 1'b0;
                    end else begin
                        tcnt_d  = '0;
                        oe_d    = 1'b0;
                        state_d = S_DISPLAY;
                    end
                end
                S_DISPLAY: begin
                    if (tcnt_q == ON_LAST) begin
                        tcnt_d  = '0;
                        oe_d    = 1'b1;
                        state_d = S_BLANK;
                    end else begin
                        tcnt_d = tnext;
                    end
                end
                S_BLANK: begin
                    if (tcnt_q == BLANK_LAST) begin
                        tcnt_d = '0;
                        mr_d   = 1'b0;
                        if (!phase_q) begin
                            phase_d = 1'b1;
                            state_d = S_CLEAR;
                        end else begin
                            // Row boundary: the only place en is honoured
                            // mid-frame, and row 7->0 is the swap point.
                            phase_d = 1'b0;
                            row_d   = row_q + 3'd1;
                            swap    = (row_q == 3'd7) && full_q;
                            state_d = en ? S_CLEAR : S_IDLE;
                        end
                    end else begin
                        tcnt_d = tnext;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (swap) begin
            active_d      = shadow_q;
            full_d        = 1'b0;
            frame_start_d = 1'b1;
        end

        // Swap needs full_q=1, accept needs full_q=0: never both in one cycle.
        if (frame_valid && !full_q) begin
            shadow_d = frame_in;
            full_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            div_q         <= '0;
            tcnt_q        <= '0;
            row_q         <= 3'd0;
            phase_q       <= 1'b0;
            active_q      <= '0;
            shadow_q      <= '0;
            full_q        <= 1'b0;
            shcp_q        <= 1'b0;
            stcp_q        <= 1'b0;
            mr_q          <= 1'b0;
            oe_q          <= 1'b1;
            ds_q          <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            div_q         <= div_d;
            tcnt_q        <= tcnt_d;
            row_q         <= row_d;
            phase_q       <= phase_d;
            active_q      <= active_d;
            shadow_q      <= shadow_d;
            full_q        <= full_d;
            shcp_q        <= shcp_d;
            stcp_q        <= stcp_d;
            mr_q          <= mr_d;
            oe_q          <= oe_d;
            ds_q          <= ds_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign frame_ready = ~full_q;
    assign rowsOut     = 8'h01 << row_q;
    assign shcp        = shcp_q;
    assign stcp        = stcp_q;
    assign mr          = mr_q;
    assign oe          = oe_q;
    assign ds          = ds_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_led_scan_scheduler.sv
// Bench for led_scan_scheduler: a tick-level model (position within a phase,
// row, phase, active/shadow frames) predicts every output each cycle, and a
// few hand-computed literals pin the model's view of the sequence.
module tb_led_scan_scheduler;

    localparam int DIV  = 2;
    localparam int ON   = 4;
    localparam int CLR  = 2;
    localparam int BLK  = 2;
    localparam int PLEN = CLR + 48 + 2 + ON + BLK;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         frame_valid = 1'b0;
    logic [191:0] frame_in = '0;
    logic         frame_ready, shcp, stcp, mr, oe, ds, frame_start;
    logic [7:0]   rowsOut;

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    led_scan_scheduler #(.DIV(DIV), .ON_TICKS(ON), .CLR_TICKS(CLR), .BLANK_TICKS(BLK)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .frame_in(frame_in),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .rowsOut(rowsOut),
        .shcp(shcp), .stcp(stcp), .mr(mr), .oe(oe), .ds(ds), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // ---------------- model state ----------------
    bit           m_run, m_full, m_fs;
    int           m_pos, m_row, m_phase, m_div;
    logic [191:0] m_act, m_shd;

    // ---------------- waveform monitor ----------------
    logic         p_shcp = 0, p_stcp = 0, p_oe = 1;
    logic [7:0]   p_rows = 8'h01;
    int           bitcnt = 0, last_rise = 0, oerun = 0;
    logic [23:0]  cur_word = '0;
    logic [23:0]  words[$];
    int           nbits[$];
    int           oeruns[$];
    logic [7:0]   rowseq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic to_fail(input string nm);
        ncmp++;
        nerr++;
        $display("FAIL %s: got timeout, expected event within budget (cycle %0d)", nm, cyc);
    endtask

    function automatic logic [191:0] rnd_frame();
        logic [191:0] f;
        for (int i = 0; i < 6; i++) f[i*32 +: 32] = $urandom;
        return f;
    endfunction

    task automatic model_reset();
        m_run = 0; m_full = 0; m_fs = 0;
        m_pos = 0; m_row = 0; m_phase = 0; m_div = 0;
        m_act = '0; m_shd = '0;
    endtask

    task automatic model_step();
        bit tick, old_full;
        tick     = (m_div == DIV - 1);
        m_div    = (m_div + 1) % DIV;
        old_full = m_full;
        m_fs     = 0;
        if (tick) begin
            if (!m_run) begin
                if (en) begin
                    if (old_full) begin m_act = m_shd; m_full = 0; m_fs = 1; end
                    m_run = 1; m_row = 0; m_phase = 0; m_pos = 0;
                end
            end else if (m_pos == PLEN - 1) begin
                m_pos = 0;
                if (m_phase == 0) m_phase = 1;
                else begin
                    m_phase = 0;
                    m_row   = (m_row + 1) % 8;
                    if (m_row == 0 && old_full) begin m_act = m_shd; m_full = 0; m_fs = 1; end
                    if (!en) m_run = 0;
                end
            end else begin
                m_pos++;
            end
        end
        if (frame_valid && !old_full) begin
            m_shd  = frame_in;
            m_full = 1;
        end
    endtask

    // Compare process: advance model on each edge, check all outputs 1 ns later.
    initial begin
        logic [23:0] w;
        int          s;
        logic        e_mr, e_oe, e_sh, e_st, e_ds;
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset_n) model_reset(); else model_step();
            #1;
            e_mr = 0; e_oe = 1; e_sh = 0; e_st = 0; e_ds = 0;
            if (m_run) begin
                w = m_act[m_row*24 +: 24] & (m_phase ? 24'hFF00FF : 24'h00FF00);
                if (m_pos >= CLR && m_pos < CLR + 48) begin
                    s = m_pos - CLR;
                    e_mr = 1; e_ds = w[s/2]; e_sh = ((s % 2) == 1);
                end else if (m_pos == CLR + 48) begin
                    e_mr = 1; e_st = 1; e_ds = w[23];
                end else if (m_pos > CLR + 48) begin
                    e_mr = 1;
                    e_oe = !(m_pos >= CLR + 50 && m_pos < CLR + 50 + ON);
                end
            end
            chk("mr", mr, e_mr);
            chk("oe", oe, e_oe);
            chk("shcp", shcp, e_sh);
            chk("stcp", stcp, e_st);
            chk("ds", ds, e_ds);
            chk("rowsOut", rowsOut, 8'h01 << m_row);
            chk("frame_ready", frame_ready, !m_full);
            chk("frame_start", frame_start, m_fs);

            if (!reset_n) begin
                bitcnt = 0; oerun = 0; cur_word = '0;
            end else begin
                if (shcp && !p_shcp) begin
                    if (bitcnt > 0) chk("shcp_gap", cyc - last_rise, 4);
                    last_rise = cyc;
                    if (bitcnt < 24) cur_word[bitcnt] = ds;
                    bitcnt++;
                end
                if (stcp && !p_stcp) begin
                    words.push_back(cur_word);
                    nbits.push_back(bitcnt);
                    bitcnt = 0; cur_word = '0;
                end
                if (!oe) oerun++;
                else if (!p_oe) begin oeruns.push_back(oerun); oerun = 0; end
                if (rowsOut != p_rows) begin
                    chk("oe_at_row_change", oe, 1);
                    rowseq.push_back(rowsOut);
                end
            end
            p_shcp = shcp; p_stcp = stcp; p_oe = oe; p_rows = rowsOut;
        end
    end

    // Stimulus
    initial begin
        logic [191:0] f1, f2, f3;
        logic [7:0]   one;
        one = 8'h01;

        repeat (3) @(negedge clk);
        chk("rst_oe", oe, 1);
        chk("rst_mr", mr, 0);
        chk("rst_rows", rowsOut, 8'h01);
        chk("rst_ready", frame_ready, 1);
        chk("rst_shcp", shcp, 0);
        reset_n = 1;

        // First frame, row 0 = A5_3C_0F, loaded while idle.
        f1 = rnd_frame();
        f1[23:0] = 24'hA53C0F;
        @(negedge clk); frame_valid = 1; frame_in = f1;
        @(negedge clk); frame_valid = 0;
        chk("ready_after_load", frame_ready, 0);
        en = 1;
        for (int i = 0; i < 600 && words.size() < 2; i++) @(negedge clk);
        if (words.size() < 2 || oeruns.size() < 1) to_fail("first_words");
        else begin
            chk("row0_ph0_word", words[0], 24'h003C00);
            chk("row0_ph1_word", words[1], 24'hA5000F);
            chk("bits_per_latch", nbits[0], 24);
            chk("first_on_len", oeruns[0], 8);
        end

        // Two frames offered back to back: second waits for the wrap swap.
        f2 = rnd_frame();
        f3 = rnd_frame();
        frame_valid = 1; frame_in = f2;
        @(negedge clk); frame_in = f3;
        @(negedge clk);
        chk("ready_held", frame_ready, 0);
        for (int i = 0; i < 2500 && frame_start !== 1'b1; i++) @(negedge clk);
        if (frame_start !== 1'b1) to_fail("wrap_swap");
        else begin
            chk("swap_row", rowsOut, 8'h01);
            chk("ready_at_swap", frame_ready, 1);
            if (rowseq.size() < 8) to_fail("row_seq_len");
            else for (int i = 0; i < 8; i++) chk("row_seq", rowseq[i], one << ((i + 1) % 8));
            @(negedge clk);
            chk("f3_accepted", frame_ready, 0);
        end
        frame_valid = 0;

        // Random frame traffic.
        for (int i = 0; i < 3700; i++) begin
            @(negedge clk);
            frame_valid = ($urandom_range(0, 7) == 0);
            frame_in    = rnd_frame();
        end
        frame_valid = 0;

        // Drop en during row 3, phase 0 display.
        for (int i = 0; i < 4000 && !(m_run && m_row == 3 && m_phase == 0 &&
             m_pos >= CLR + 50 && m_pos < CLR + 50 + ON); i++) @(negedge clk);
        if (!(m_run && m_row == 3 && m_phase == 0)) to_fail("row3_display");
        chk("row3_display_oe", oe, 0);
        en = 0;
        for (int i = 0; i < 400 && m_run; i++) @(negedge clk);
        if (m_run) to_fail("enter_idle");
        else begin
            chk("idle_rows", rowsOut, 8'h10);
            chk("idle_oe", oe, 1);
        end
        repeat (40) @(negedge clk);
        chk("idle_oe_hold", oe, 1);
        chk("idle_mr", mr, 0);
        en = 1;
        for (int i = 0; i < 10 && !m_run; i++) @(negedge clk);
        if (!m_run) to_fail("restart");
        chk("restart_rows", rowsOut, 8'h01);
        chk("restart_mr", mr, 0);

        // Fill the shadow, then reset in the middle of row 1's shift.
        @(negedge clk); frame_valid = 1; frame_in = rnd_frame();
        @(negedge clk); frame_valid = 0;
        chk("ready_f4", frame_ready, 0);
        for (int i = 0; i < 600 && !(m_run && m_row == 1 && m_pos >= CLR + 4 && m_pos < CLR + 40); i++)
            @(negedge clk);
        if (!(m_run && m_row == 1)) to_fail("row1_shift");
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        chk("rst_mid_oe", oe, 1);
        chk("rst_mid_mr", mr, 0);
        chk("rst_mid_shcp", shcp, 0);
        chk("rst_mid_ds", ds, 0);
        chk("rst_mid_stcp", stcp, 0);
        chk("rst_mid_rows", rowsOut, 8'h01);
        chk("rst_mid_ready", frame_ready, 1);
        words.delete();
        repeat (2) @(negedge clk);
        reset_n = 1;
        for (int i = 0; i < 600 && words.size() < 4; i++) @(negedge clk);
        if (words.size() < 4) to_fail("post_reset_words");
        else for (int i = 0; i < 4; i++) chk("cleared_word", words[i], 24'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
